alu_seq_driver: RTL and testbench

ALU_SEQ_DRIVER -- requirements
Module: alu_seq_driver

---
 rtl/alu_seq_pkg.sv | 20 ++
 rtl/alu_cmd_fifo.sv | 58 +++++
 rtl/alu_seq_driver.sv | 144 ++++++++++++++
 tb/tb_alu_seq_driver.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencing driver: opcode encoding and the driver FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_seq_pkg;

    typedef logic [1:0] opcode_t;

    localparam opcode_t OP_ADD = 2'd0;
    localparam opcode_t OP_SUB = 2'd1;
    localparam opcode_t OP_AND = 2'd2;
    localparam opcode_t OP_OR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command buffer: DEPTH-entry FIFO of {op, a, b} words, head visible on pop_dat.
// Latency: a push is visible (empty deasserts) the cycle after the pushing edge.
// Backpressure: full blocks pushes; pops of an empty FIFO are ignored.
// Ports: clk, rst_n (async active-low), push/push_dat, pop/pop_dat, full, empty.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 18,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] pop_dat,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_seq_driver.sv
// Sequences buffered commands through an external registered ALU and returns tagged results in order.
// Latency: command accepted into an empty FIFO at edge E0 gives res_valid after E3; one result per 3 cycles when streaming.
// Backpressure: res_ready low holds the result and stalls the FSM; the FIFO then fills and drops cmd_ready.
// Ports: clk, rst_n; cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op in; alu_a/alu_b/alu_op out, alu_c in;
//        res_valid/res_ready/res_data/res_op out; busy out. Optional macro ALU_SEQ_DRIVER_CHECK_EN adds
//        output err (sticky flag set when a captured ALU result disagrees with an internal reference).
module alu_seq_driver
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic [1:0]   cmd_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_op,
    input  logic [W-1:0] alu_c,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic [1:0]   res_op,
    output logic         busy
`ifdef ALU_SEQ_DRIVER_CHECK_EN
    ,
    output logic         err
`endif
);

    localparam int FW = 2 * W + 2;

    state_t        state;
    state_t        state_nxt;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [FW-1:0] fifo_dat;
    opcode_t       head_op;
    logic [W-1:0]  head_a;
    logic [W-1:0]  head_b;

    assign {head_op, head_a, head_b} = fifo_dat;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .DW    (FW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (cmd_valid),
        .push_dat ({cmd_op, cmd_a, cmd_b}),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign cmd_ready = !fifo_full;
    assign res_valid = (state == RESP);
    assign busy      = (state != IDLE) || !fifo_empty;

    // fifo_empty comes from the registered count, so a command pushed on
    // the same edge the FSM looks at the FIFO is only popped one cycle later.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT:  state_nxt = RESP;
            RESP: begin
                if (res_ready) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next command, no IDLE bubble.
                        pop       = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            res_data <= '0;
            res_op   <= '0;
        end else begin
            state <= state_nxt;
            // Operands move only on a pop so the ALU sees them held through ISSUE and WAIT.
            if (pop) begin
                alu_a  <= head_a;
                alu_b  <= head_b;
                alu_op <= head_op;
            end
            // The ALU registered the ISSUE-cycle operands, so alu_c is valid during WAIT.
            if (state == WAIT) begin
                res_data <= alu_c;
                res_op   <= alu_op;
            end
        end
    end

`ifdef ALU_SEQ_DRIVER_CHECK_EN
    logic [W-1:0] ref_c;

    always_comb begin
        ref_c = '0;
        unique case (alu_op)
            OP_ADD:  ref_c = alu_a + alu_b;
            OP_SUB:  ref_c = alu_a - alu_b;
            OP_AND:  ref_c = alu_a & alu_b;
            OP_OR:   ref_c = alu_a | alu_b;
            default: ref_c = '0;
        endcase
    end

    // Judged on the same edge that captures res_data, so err rises with the bad RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == WAIT && alu_c != ref_c) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq_driver.sv
// Self-checking bench for alu_seq_driver: registered ALU model, reference result queue, scenario tasks.
// Latency: checks the 3-edge accept-to-result latency and 3-cycle streaming cadence.
// Backpressure: stalls res_ready to fill the FIFO and checks ordering and result stability.
module tb_alu_seq_driver;

    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [W-1:0] cmd_a     = '0;
    logic [W-1:0] cmd_b     = '0;
    logic [1:0]   cmd_op    = '0;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_op;
    logic [W-1:0] alu_c;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_data;
    logic [1:0]   res_op;
    logic         busy;
`ifdef ALU_SEQ_DRIVER_CHECK_EN
    logic         err;
`endif

    logic         alu_zero = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    int         acc_q[$];
    int         first_q[$];
    int         stab_viol = 0;
    int         vld_seen  = 0;

    alu_seq_driver #(.DEPTH(DEPTH), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_c     (alu_c),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_op    (res_op),
        .busy      (busy)
`ifdef ALU_SEQ_DRIVER_CHECK_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    // Sequential ALU: result registered one clock after sampling the operands.
    always @(posedge clk) begin
        if (alu_zero) alu_c <= '0;
        else if (alu_op == 2'd0) alu_c <= alu_a + alu_b;
        else if (alu_op == 2'd1) alu_c <= alu_a - alu_b;
        else if (alu_op == 2'd2) alu_c <= alu_a & alu_b;
        else alu_c <= alu_a | alu_b;
    end

    function automatic logic [7:0] model(input int a, input int b, input int op);
        int r;
        case (op)
            0:       r = (a + b) % 256;
            1:       r = (a - b + 256) % 256;
            2:       r = a & b;
            default: r = a | b;
        endcase
        return r[7:0];
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Inputs change at posedge+1, so at negedge everything seen equals what the next edge samples.
    logic       pend = 1'b0;
    logic [9:0] held = '0;
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back({model(int'(cmd_a), int'(cmd_b), int'(cmd_op)), cmd_op});
                acc_q.push_back(cyc + 1);
            end
            if (res_valid) begin
                vld_seen++;
                if (!pend) begin
                    pend = 1'b1;
                    held = {res_data, res_op};
                    first_q.push_back(cyc);
                end else if ({res_data, res_op} !== held) begin
                    stab_viol++;
                end
                if (res_ready) begin
                    got_q.push_back({res_data, res_op});
                    pend = 1'b0;
                end
            end
        end else begin
            pend = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog");
    end

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        acc_q.delete();
        first_q.delete();
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        bit ok = 1'b0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: cmd_ready stayed 0, required 1 within 300 cycles");
        end
    endtask

    task automatic wait_results(input int n, input int budget);
        int i = 0;
        while (got_q.size() < n && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        if (got_q.size() < n) begin
            n_cmp++; n_fail++;
            $display("FAIL result_timeout: got %0d results, required %0d", got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready); end
        n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b, required 0", res_valid); end
        n_cmp++; if ({res_data, res_op} !== 10'd0) begin n_fail++; $display("FAIL reset_res: got %h, required 0", {res_data, res_op}); end
        n_cmp++; if ({alu_a, alu_b, alu_op} !== 18'd0) begin n_fail++; $display("FAIL reset_alu: got %h, required 0", {alu_a, alu_b, alu_op}); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        clear_q();
        res_ready = 1'b1;
        send_cmd(8'd7, 8'd3, 2'd0);
        wait_results(1, 50);
        if (got_q.size() >= 1) begin
            n_cmp++; if (got_q[0] !== {8'd10, 2'd0}) begin n_fail++; $display("FAIL single_result: got %h, required %h", got_q[0], {8'd10, 2'd0}); end
            n_cmp++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL single_model: got %h, required %h", got_q[0], exp_q[0]); end
            n_cmp++; if (first_q[0] - acc_q[0] !== 3) begin n_fail++; $display("FAIL single_latency: got %0d edges, required 3", first_q[0] - acc_q[0]); end
        end
        repeat (2) @(posedge clk); #1;
        n_cmp++; if ({busy, res_valid} !== 2'b00) begin n_fail++; $display("FAIL single_idle: got busy,res_valid=%b, required 00", {busy, res_valid}); end
    endtask

    task automatic test_burst();
        logic [9:0] want [4];
        want[0] = {8'd4, 2'd1};
        want[1] = {8'd3, 2'd2};
        want[2] = {8'd7, 2'd3};
        want[3] = {8'd44, 2'd0};
        clear_q();
        res_ready = 1'b1;
        send_cmd(8'd7, 8'd3, 2'd1);
        send_cmd(8'd7, 8'd3, 2'd2);
        send_cmd(8'd7, 8'd3, 2'd3);
        send_cmd(8'd200, 8'd100, 2'd0);
        wait_results(4, 100);
        if (got_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (got_q[i] !== want[i]) begin n_fail++; $display("FAIL burst_result[%0d]: got %h, required %h", i, got_q[i], want[i]); end
                n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL burst_model[%0d]: got %h, required %h", i, got_q[i], exp_q[i]); end
            end
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (first_q[i+1] - first_q[i] !== 3) begin n_fail++; $display("FAIL burst_cadence[%0d]: got %0d cycles, required 3", i, first_q[i+1] - first_q[i]); end
            end
        end
    endtask

    task automatic test_stall();
        int base = stab_viol;
        int low_cnt = 0;
        clear_q();
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_cmd(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
        end
        repeat (2) @(posedge clk); #1;
        fork
            send_cmd(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (!cmd_ready) low_cnt++;
                end
                n_cmp++; if (low_cnt !== 20) begin n_fail++; $display("FAIL stall_cmd_ready: low for %0d cycles, required 20", low_cnt); end
                n_cmp++; if ({res_valid, busy} !== 2'b11) begin n_fail++; $display("FAIL stall_valid_busy: got %b, required 11", {res_valid, busy}); end
                @(posedge clk); #1;
                res_ready = 1'b1;
            end
        join
        wait_results(6, 100);
        repeat (10) @(posedge clk); #1;
        n_cmp++; if (got_q.size() !== 6) begin n_fail++; $display("FAIL stall_count: got %0d results, required 6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_model[%0d]: got %h, required %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (stab_viol - base !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes while held, required 0", stab_viol - base); end
    endtask

    task automatic test_underflow();
        clear_q();
        res_ready = 1'b1;
        send_cmd(8'd3, 8'd7, 2'd1);
        wait_results(1, 50);
        if (got_q.size() >= 1) begin
            n_cmp++; if (got_q[0] !== {8'hFC, 2'd1}) begin n_fail++; $display("FAIL underflow: got %h, required %h", got_q[0], {8'hFC, 2'd1}); end
        end
    endtask

    task automatic test_random();
        int base = stab_viol;
        bit done = 1'b0;
        clear_q();
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    send_cmd(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                done = 1'b1;
            end
            begin
                for (int k = 0; k < 3000 && !done; k++) begin
                    @(posedge clk); #1;
                    res_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        res_ready = 1'b1;
        wait_results(24, 300);
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL random_count: got %0d results, required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_model[%0d]: got %h, required %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (stab_viol - base !== 0) begin n_fail++; $display("FAIL random_stable: got %0d changes while held, required 0", stab_viol - base); end
    endtask

    task automatic test_reset_mid();
        int base;
        clear_q();
        res_ready = 1'b1;
        // Back-to-back: first command is in WAIT with two more queued after the third accept.
        send_cmd(8'd11, 8'd22, 2'd0);
        send_cmd(8'd33, 8'd44, 2'd3);
        send_cmd(8'd55, 8'd66, 2'd1);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({res_valid, busy, cmd_ready} !== 3'b001) begin n_fail++; $display("FAIL midreset_flags: got %b, required 001", {res_valid, busy, cmd_ready}); end
        n_cmp++; if ({alu_a, alu_b, alu_op, res_data, res_op} !== 28'd0) begin n_fail++; $display("FAIL midreset_regs: got %h, required 0", {alu_a, alu_b, alu_op, res_data, res_op}); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        base = vld_seen;
        repeat (20) @(posedge clk); #1;
        n_cmp++; if (vld_seen - base !== 0) begin n_fail++; $display("FAIL midreset_no_result: got %0d valid cycles, required 0", vld_seen - base); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b, required 0", busy); end
        send_cmd(8'd9, 8'd6, 2'd2);
        wait_results(1, 50);
        if (got_q.size() >= 1) begin
            n_cmp++; if (got_q[0] !== {8'd0, 2'd2}) begin n_fail++; $display("FAIL midreset_recover: got %h, required %h", got_q[0], {8'd0, 2'd2}); end
        end
    endtask

`ifdef ALU_SEQ_DRIVER_CHECK_EN
    task automatic test_err();
        clear_q();
        res_ready = 1'b1;
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_initial: got %b, required 0", err); end
        alu_zero = 1'b1;
        send_cmd(8'd1, 8'd1, 2'd0);
        wait_results(1, 50);
        alu_zero = 1'b0;
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_raise: got %b, required 1", err); end
        send_cmd(8'd1, 8'd1, 2'd0);
        wait_results(2, 50);
        if (got_q.size() >= 2) begin
            n_cmp++; if (got_q[1] !== {8'd2, 2'd0}) begin n_fail++; $display("FAIL err_good_result: got %h, required %h", got_q[1], {8'd2, 2'd0}); end
        end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b, required 1", err); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_reset: got %b, required 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_stall();
        test_underflow();
        test_random();
        test_reset_mid();
`ifdef ALU_SEQ_DRIVER_CHECK_EN
        test_err();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
